// File: rtl/id_exe_stage_reg_if.sv
// ID-to-EXE pipeline boundary: decoded ID fields in, registered EXE fields out.
// Also carries the stall/flush controls and the combinational ID hold request.
interface id_exe_stage_reg_if;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [31:0] id_pc_out;
    logic        id_GPR_we;
    logic [4:0]  id_GPR_waddr;
    logic [1:0]  id_wdata_select;
    logic [4:0]  id_alu_op;
    logic        mem_stall;
    logic        flush;

    logic        exe_valid;
    logic        exe_GPR_we;
    logic [4:0]  exe_GPR_waddr;
    logic [1:0]  exe_wdata_select;
    logic [4:0]  exe_alu_op;
    logic [31:0] exe_rs_data;
    logic [31:0] exe_rt_data;
    logic [31:0] exe_imm;
    logic [31:0] exe_pc_out;
    logic        id_stall;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_rs_data, id_rt_data, id_imm, id_pc_out, id_GPR_we,
               id_GPR_waddr, id_wdata_select, id_alu_op, mem_stall, flush,
        input  exe_valid, exe_GPR_we, exe_GPR_waddr, exe_wdata_select, exe_alu_op,
               exe_rs_data, exe_rt_data, exe_imm, exe_pc_out, id_stall
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_rs_data, id_rt_data, id_imm, id_pc_out, id_GPR_we,
               id_GPR_waddr, id_wdata_select, id_alu_op, mem_stall, flush,
        output exe_valid, exe_GPR_we, exe_GPR_waddr, exe_wdata_select, exe_alu_op,
               exe_rs_data, exe_rt_data, exe_imm, exe_pc_out, id_stall
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with load-use bubble insertion and deferred flush.
// Latency: 1 cycle ID->EXE; id_stall is combinational from registered EXE state.
// Backpressure: mem_stall freezes all EXE state and raises id_stall; load-use holds ID one cycle.
module id_exe_stage_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_exe_stage_reg_if.slave bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic        valid;
        logic        gpr_we;
        logic [4:0]  gpr_waddr;
        logic [1:0]  wdata_select;
        logic [4:0]  alu_op;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc_out;
    } exe_t;

    exe_t exe_r;
    exe_t id_load;
    logic flush_pend;
    logic flush_eff;
    logic load_use;
    logic rs_hit;
    logic rt_hit;

    // Only a valid load (wdata_select 00) to a nonzero register can hazard.
    assign rs_hit   = bus.id_rs_used && (bus.id_rs_addr == exe_r.gpr_waddr);
    assign rt_hit   = bus.id_rt_used && (bus.id_rt_addr == exe_r.gpr_waddr);
    assign load_use = exe_r.valid && exe_r.gpr_we && (exe_r.wdata_select == 2'b00) &&
                      (exe_r.gpr_waddr != 5'd0) && bus.id_valid && (rs_hit || rt_hit);

    assign flush_eff    = bus.flush || flush_pend;
    assign bus.id_stall = bus.mem_stall || (load_use && !flush_eff);

    always_comb begin
        id_load              = '0;
        id_load.valid        = bus.id_valid;
        id_load.gpr_we       = bus.id_GPR_we && bus.id_valid;
        id_load.gpr_waddr    = bus.id_GPR_waddr;
        id_load.wdata_select = bus.id_wdata_select;
        id_load.alu_op       = bus.id_alu_op;
        id_load.rs_data      = bus.id_rs_data;
        id_load.rt_data      = bus.id_rt_data;
        id_load.imm          = bus.id_imm;
        id_load.pc_out       = bus.id_pc_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_r      <= '0;
            flush_pend <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            // A flush seen while frozen is remembered until the freeze lifts.
            flush_pend <= bus.mem_stall && (flush_pend || bus.flush);
            if (!bus.mem_stall) begin
                if (flush_eff || load_use) begin
                    exe_r <= '0;
                end else begin
                    exe_r <= id_load;
                end
                if (!flush_eff && load_use && (bubble_cnt != {CNT_W{1'b1}})) begin
                    bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.exe_valid        = exe_r.valid;
    assign bus.exe_GPR_we       = exe_r.gpr_we;
    assign bus.exe_GPR_waddr    = exe_r.gpr_waddr;
    assign bus.exe_wdata_select = exe_r.wdata_select;
    assign bus.exe_alu_op       = exe_r.alu_op;
    assign bus.exe_rs_data      = exe_r.rs_data;
    assign bus.exe_rt_data      = exe_r.rt_data;
    assign bus.exe_imm          = exe_r.imm;
    assign bus.exe_pc_out       = exe_r.pc_out;

endmodule
